// File: rtl/config_pkg.sv
// Shared constants for the configuration frame writer: the sync word,
// the FSM state encoding and the default position of the desync flag.
package config_pkg;

  typedef logic [1:0] state_t;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  localparam int DESYNC_FLAG_POS_DEFAULT = 20;

endpackage

// File: rtl/config_frame_writer_if.sv
// Bus between the USB CDC config bridge (master) and the frame writer (slave).
// Carries the incoming word stream, the frame fabric write port and status.
interface config_frame_writer_if #(
  parameter int ROW_SEL_W = 5
);

  logic                 word_write_strobe_i;
  logic [31:0]          write_data_i;
  logic [31:0]          frame_address_o;
  logic [31:0]          frame_data_o;
  logic [ROW_SEL_W-1:0] row_select_o;
  logic                 frame_strobe_o;
  logic                 config_active_o;
  logic                 config_done_o;
  logic [15:0]          frame_count_o;

  modport master (
    output word_write_strobe_i, write_data_i,
    input  frame_address_o, frame_data_o, row_select_o, frame_strobe_o,
    input  config_active_o, config_done_o, frame_count_o
  );

  modport slave (
    input  word_write_strobe_i, write_data_i,
    output frame_address_o, frame_data_o, row_select_o, frame_strobe_o,
    output config_active_o, config_done_o, frame_count_o
  );

endinterface

// File: rtl/config_row_counter.sv
// Row counter for one frame: counts data words 0..NUM_ROWS-1 and flags the
// last row so the writer knows when to go back for the next address word.
module config_row_counter #(
  parameter int NUM_ROWS  = 16,
  parameter int ROW_SEL_W = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear,
  input  logic                 advance,
  output logic [ROW_SEL_W-1:0] row_cnt,
  output logic                 last_row
);

  assign last_row = (row_cnt == ROW_SEL_W'(NUM_ROWS - 1));

  // Clear on a new address word, step on each data word, wrap after the last row
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      row_cnt <= '0;
    end else if (clear) begin
      row_cnt <= '0;
    end else if (advance) begin
      if (last_row) begin
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + ROW_SEL_W'(1);
      end
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Configuration frame writer: turns the config word stream (sync, then
// address word followed by NUM_ROWS data words, repeated, then desync)
// into row-by-row writes to the configuration fabric.
// Optional feature: define CONFIG_FRAME_COUNT_EN to count completed frames
// on frame_count_o; otherwise frame_count_o is tied to zero.
module config_frame_writer
  import config_pkg::*;
#(
  parameter int NUM_ROWS        = 16,
  parameter int ROW_SEL_W       = 5,
  parameter int DESYNC_FLAG_POS = DESYNC_FLAG_POS_DEFAULT
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  config_frame_writer_if.slave cfg
);

  state_t               state_q;
  logic [ROW_SEL_W-1:0] row_cnt;
  logic                 last_row;
  logic                 is_sync;
  logic                 take_sync;
  logic                 take_desync;
  logic                 take_addr;
  logic                 take_data;

  // Decode what the current word means in the current state
  always_comb begin
    is_sync     = (cfg.write_data_i == SYNC_WORD);
    take_sync   = cfg.word_write_strobe_i && (state_q == ST_IDLE) && is_sync;
    take_desync = cfg.word_write_strobe_i && (state_q == ST_ADDR) && !is_sync
                  && cfg.write_data_i[DESYNC_FLAG_POS];
    take_addr   = cfg.word_write_strobe_i && (state_q == ST_ADDR) && !is_sync
                  && !cfg.write_data_i[DESYNC_FLAG_POS];
    take_data   = cfg.word_write_strobe_i && (state_q == ST_DATA);
  end

  config_row_counter #(
    .NUM_ROWS  (NUM_ROWS),
    .ROW_SEL_W (ROW_SEL_W)
  ) u_row_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear     (take_addr),
    .advance   (take_data),
    .row_cnt   (row_cnt),
    .last_row  (last_row)
  );

  // State transitions; an unused encoding falls back to IDLE
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (take_sync) state_q <= ST_ADDR;
        ST_ADDR: begin
          if (take_desync) state_q <= ST_IDLE;
          else if (take_addr) state_q <= ST_DATA;
        end
        ST_DATA: if (take_data && last_row) state_q <= ST_ADDR;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output registers: strobe and row select are single-cycle, the rest hold
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg.frame_address_o <= '0;
      cfg.frame_data_o    <= '0;
      cfg.row_select_o    <= '0;
      cfg.frame_strobe_o  <= 1'b0;
      cfg.config_active_o <= 1'b0;
      cfg.config_done_o   <= 1'b0;
    end else begin
      cfg.frame_strobe_o <= take_data;
      cfg.row_select_o   <= take_data ? (row_cnt + ROW_SEL_W'(1)) : '0;
      if (take_data) begin
        cfg.frame_data_o <= cfg.write_data_i;
      end
      if (take_addr) begin
        cfg.frame_address_o <= cfg.write_data_i;
      end
      if (take_sync) begin
        cfg.config_active_o <= 1'b1;
        cfg.config_done_o   <= 1'b0;
      end else if (take_desync) begin
        cfg.config_active_o <= 1'b0;
        cfg.config_done_o   <= 1'b1;
      end
    end
  end

`ifdef CONFIG_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter, saturating, restarted by each accepted sync word
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_count_q <= '0;
    end else if (take_sync) begin
      frame_count_q <= '0;
    end else if (take_data && last_row && (frame_count_q != 16'hFFFF)) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign cfg.frame_count_o = frame_count_q;
`else
  assign cfg.frame_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer with NUM_ROWS=4.
// A vector table drives one word (or idle cycle) per clock and lists the
// outputs expected right after that edge; reset and post-reset behaviour
// are covered by a hand-written sequence.
module tb_config_frame_writer;

  localparam int NUM_ROWS  = 4;
  localparam int ROW_SEL_W = 5;
  localparam int NVEC      = 25;

`ifdef CONFIG_FRAME_COUNT_EN
  localparam logic [15:0] EXP_FRAMES = 16'd2;
`else
  localparam logic [15:0] EXP_FRAMES = 16'd0;
`endif

  logic clk;
  logic reset_n;

  int total;
  int bad;

  config_frame_writer_if #(.ROW_SEL_W(ROW_SEL_W)) cfg ();

  config_frame_writer #(
    .NUM_ROWS        (NUM_ROWS),
    .ROW_SEL_W       (ROW_SEL_W),
    .DESYNC_FLAG_POS (20)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .cfg       (cfg)
  );

  typedef struct packed {
    logic        stb;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] fdata;
    logic [4:0]  row;
    logic        fstb;
    logic        act;
    logic        done;
  } vec_t;

  vec_t vecs [NVEC];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] addr, input logic [31:0] fdata,
                             input logic [4:0] row, input logic fstb, input logic act,
                             input logic done);
    checkField({tag, " frame_address"}, cfg.frame_address_o, addr);
    checkField({tag, " frame_data"}, cfg.frame_data_o, fdata);
    checkField({tag, " row_select"}, 32'(cfg.row_select_o), 32'(row));
    checkField({tag, " frame_strobe"}, 32'(cfg.frame_strobe_o), 32'(fstb));
    checkField({tag, " config_active"}, 32'(cfg.config_active_o), 32'(act));
    checkField({tag, " config_done"}, 32'(cfg.config_done_o), 32'(done));
  endtask

  // Drive one word (or an idle cycle) for exactly one clock, leave time at edge+1
  task automatic applyStimulus(input logic stb, input logic [31:0] data);
    @(negedge clk);
    cfg.word_write_strobe_i = stb;
    cfg.write_data_i        = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    cfg.word_write_strobe_i = 1'b0;
    cfg.write_data_i        = 32'h0;

    //            stb   data           addr           fdata          row  fstb  act   done
    vecs[0]  = '{1'b1, 32'h1234_5678, 32'h0,         32'h0,         5'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0010_0000, 32'h0,         32'h0,         5'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'hFAB0_FAB1, 32'h0,         32'h0,         5'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'hFAB0_FAB1, 32'h0,         32'h0,         5'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0003, 32'h3,         32'h0,         5'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_00A0, 32'h3,         32'hA0,        5'd1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h3,         32'hA0,        5'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_00A1, 32'h3,         32'hA1,        5'd2, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_00A2, 32'h3,         32'hA2,        5'd3, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_00A3, 32'h3,         32'hA3,        5'd4, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h3,         32'hA3,        5'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h0010_0000, 32'h3,         32'hA3,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_00A5, 32'h3,         32'hA3,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'hFAB0_FAB1, 32'h3,         32'hA3,        5'd0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0007, 32'h7,         32'hA3,        5'd0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_00B0, 32'h7,         32'hB0,        5'd1, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 32'h0000_00B1, 32'h7,         32'hB1,        5'd2, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 32'h0000_00B2, 32'h7,         32'hB2,        5'd3, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_00B3, 32'h7,         32'hB3,        5'd4, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 32'h0000_0008, 32'h8,         32'hB3,        5'd0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 32'hFAB0_FAB1, 32'h8,         32'hFAB0_FAB1, 5'd1, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 32'h0010_0000, 32'h8,         32'h0010_0000, 5'd2, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 32'h0000_00C2, 32'h8,         32'hC2,        5'd3, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 32'h0000_00C3, 32'h8,         32'hC3,        5'd4, 1'b1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 32'h0000_0000, 32'h8,         32'hC3,        5'd0, 1'b0, 1'b1, 1'b0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkField("reset frame_count", 32'(cfg.frame_count_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven main sequence
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].stb, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].addr, vecs[i].fdata, vecs[i].row,
                  vecs[i].fstb, vecs[i].act, vecs[i].done);
    end
    checkField("frame_count after two frames", 32'(cfg.frame_count_o), 32'(EXP_FRAMES));

    // Reset in the middle of a frame, after row 2 has been written
    applyStimulus(1'b1, 32'h0010_0000);
    applyStimulus(1'b1, 32'hFAB0_FAB1);
    applyStimulus(1'b1, 32'h0000_0005);
    applyStimulus(1'b1, 32'h0000_00D0);
    applyStimulus(1'b1, 32'h0000_00D1);
    checkOutput("pre-reset", 32'h5, 32'hD1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    cfg.word_write_strobe_i = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset edge", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkField("reset frame_count mid", 32'(cfg.frame_count_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Remaining data words of the broken frame must be ignored
    applyStimulus(1'b1, 32'h0000_00D2);
    checkOutput("post-reset D2", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_00D3);
    checkOutput("post-reset D3", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // A fresh sync starts over from row 1
    applyStimulus(1'b1, 32'hFAB0_FAB1);
    checkOutput("resync", 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0009);
    checkOutput("resync addr", 32'h9, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_00E0);
    checkOutput("resync row1", 32'h9, 32'hE0, 5'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("resync idle", 32'h9, 32'hE0, 5'd0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 16: data words (rows) per frame; legal range 2..31.
REQ-002 SHALL have parameter ROW_SEL_W, default 5: width of row_select_o; 2**ROW_SEL_W SHALL be greater than NUM_ROWS.
REQ-003 SHALL have parameter DESYNC_FLAG_POS, default 20: address-word bit that marks end of configuration.
REQ-004 SHALL have input clk_i, 1 bit: clock, rising edge.
REQ-005 SHALL have input reset_n_i, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have input word_write_strobe_i, 1 bit: one-cycle pulse, write_data_i valid.
REQ-007 SHALL have input write_data_i, 32 bits: configuration word from the USB CDC config bridge.
REQ-008 SHALL have output frame_address_o, 32 bits: column select of the frame being written.
REQ-009 SHALL have output frame_data_o, 32 bits: data word for the currently selected row.
REQ-010 SHALL have output row_select_o, ROW_SEL_W bits: row number 1..NUM_ROWS; 0 means no row selected.
REQ-011 SHALL have output frame_strobe_o, 1 bit: one-cycle pulse; fabric latches frame_data_o into the selected row.
REQ-012 SHALL have output config_active_o, 1 bit: high from sync word until desync.
REQ-013 SHALL have output config_done_o, 1 bit: sticky, set on desync, cleared on the next sync word.
REQ-014 SHALL have output frame_count_o, 16 bits: completed frames (see Configuration).

Function
REQ-015 SHALL implement states IDLE, ADDR and DATA, advancing only on cycles where word_write_strobe_i=1.
REQ-016 IDLE: write_data_i==32'hFAB0_FAB1 SHALL go to ADDR and set config_active_o=1 and config_done_o=0; all other words SHALL be ignored.
REQ-017 ADDR: the sync word SHALL be ignored and the state held, with this check taking priority over the desync check.
REQ-018 ADDR: any other word with bit DESYNC_FLAG_POS=1 SHALL go to IDLE, set config_active_o=0 and config_done_o=1, and leave frame_address_o unchanged.
REQ-019 ADDR: any other word SHALL be loaded into frame_address_o, clear the row counter and go to DATA.
REQ-020 DATA: each word SHALL be registered into frame_data_o, with row_select_o=row counter+1 and frame_strobe_o=1 on the following cycle (latency 1).
REQ-021 DATA: the row counter SHALL increment on each word and the state SHALL return to ADDR after word NUM_ROWS; DATA SHALL not interpret sync or desync patterns.
REQ-022 frame_strobe_o SHALL be high exactly one cycle per data word; row_select_o SHALL return to 0 on the cycle after the strobe unless a new data word arrived.
REQ-023 SHALL accept strobes on consecutive cycles with no lost words, including the last data word followed immediately by an address word.
REQ-024 frame_data_o and frame_address_o SHALL hold their values until overwritten.
REQ-025 Strobes with the state unchanged SHALL NOT alter any output.

Reset
REQ-026 Assertion of reset_n_i, including mid-frame, SHALL immediately force: state IDLE, row counter 0, all outputs 0.
REQ-027 After reset the block SHALL require a new sync word; partially written frames SHALL NOT be resumed.

Configuration
REQ-028 With macro CONFIG_FRAME_COUNT_EN defined, frame_count_o SHALL increment on each completed frame, saturate at 16'hFFFF, and clear on every accepted sync word.
REQ-029 Without CONFIG_FRAME_COUNT_EN, frame_count_o SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-030 SHALL take the sync word 32'hFAB0_FAB1, the state encoding and the default DESYNC_FLAG_POS from shared package config_pkg.
REQ-031 SHALL place the row counter and last-row detection in sub-module config_row_counter (parameterised by NUM_ROWS and ROW_SEL_W).

Verification (NUM_ROWS=4)
REQ-032 Reset scenario SHALL check: reset asserted during DATA at row 2 -> all outputs 0 next edge; later data words ignored until sync.
REQ-033 Frame scenario SHALL check: sync, 32'h0000_0003, then 4 words 32'hA0..A3 -> frame_address_o=3; frame_strobe_o pulses with row_select_o 1,2,3,4 and frame_data_o A0..A3.
REQ-034 Desync scenario SHALL check: after a frame, 32'h0010_0000 -> config_active_o=0, config_done_o=1, frame_address_o still 3.
REQ-035 Ignore scenario SHALL check: in IDLE, 32'h1234_5678 then 32'h0010_0000 -> no output change; a repeated sync word in ADDR -> state stays ADDR.
REQ-036 Back-to-back scenario SHALL check: strobe every cycle, sync, addr 7, 4 data, addr 8, 4 data -> 8 strobes; with CONFIG_FRAME_COUNT_EN, frame_count_o=2.
